operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Addressing-mode sequencer directly upstream of the register file.
- Takes a 6-bit PDP-11 operand specifier (mode, reg) and drives register-file selects and write-back to implement modes 0-7, including autoincrement, autodecrement and index fetch.
- Uses a request/acknowledge memory port to fetch index words, pointers and the operand.
- Delivers effective address and operand to the execute stage.

Parameters:
- AW, 16, address/data width; fixed at 16 for PDP-11.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a fetch; sampled only when busy=0.
- spec  in  6  operand specifier; [5:3] mode, [2:0] register.
- byte_op  in  1  byte instruction.
- fetch  in  1  1 = read the operand; 0 = compute EA only (destination write).
- rf_sela  out  3  register-file read select A.
- rf_selb  out  3  register-file read select B and write select.
- rf_we  out  1  register-file write enable.
- rf_w  out  16  register-file write data.
- rf_a  in  16  register-file bus A; combinational read.
- mem_req  out  1  memory read request.
- mem_addr  out  16  memory word address.
- mem_ack  in  1  memory data valid.
- mem_rdata  in  16  memory read data.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- ea  out  16  effective address; valid with done when ea_valid=1.
- ea_valid  out  1  1 for modes 1-7.
- operand  out  16  operand value; valid with done.
- odd_err  out  1  one-cycle pulse: word access to an odd address; sequence aborted.

Behaviour:
- Reset (highest priority, any state): state goes to IDLE. busy, done, mem_req, rf_we, odd_err, ea_valid = 0; ea and operand = 0.
  - Register writes already committed are not rolled back.
- States: IDLE, IDX, REG, PTR, DATA, DONE. busy = (state != IDLE). start is ignored while busy.
- Start in IDLE latches spec, byte_op and fetch.
  - Modes 6/7 go to IDX; all other modes go to REG.
- step = 1 if byte_op and reg<6 and mode in {2,4}; otherwise step = 2.
- IDX:
  - sela = 7; mem_req = 1, mem_addr = PC.
  - On mem_ack: X <= mem_rdata; write PC+2 (selb = 7, we = 1); go to REG.
- REG: sela = reg; one cycle; tmp is loaded per mode:
  - mode 0, 1: tmp <= Rn.
  - mode 2, 3: tmp <= Rn; write Rn+step (mode 3 uses step = 2).
  - mode 4, 5: tmp <= Rn-step; write Rn-step (mode 5 uses step = 2).
  - mode 6, 7: tmp <= Rn+X, mod 2^16. If reg = 7, Rn is the already-incremented PC.
  - Next state: modes 3/5/7 go to PTR. Mode 0 goes to DONE with operand = Rn (byte_op: {8'h0, Rn[7:0]}). Other modes go to DATA if fetch=1, else DONE.
- PTR:
  - If tmp[0] = 1: odd_err pulse, go to IDLE, no done.
  - Otherwise mem_req with mem_addr = tmp. On mem_ack: tmp <= mem_rdata; go to DATA if fetch=1, else DONE.
- DATA:
  - Word access with tmp[0] = 1: odd_err pulse, go to IDLE.
  - Otherwise mem_addr = {tmp[15:1], 1'b0}. On mem_ack: operand <= word, or for byte_op {8'h0, tmp[0] ? hi byte : lo byte}; go to DONE.
- DONE: done = 1 for exactly one cycle. ea = tmp (held until next start). ea_valid = (mode != 0). Next state IDLE.
- Memory handshake:
  - mem_req is decoded from the state register and held with a stable mem_addr until mem_ack is sampled high. An ack in the first cycle is accepted.
  - mem_ack outside a memory state is ignored.
  - Unbounded wait; no timeout.
- rf_we is asserted for at most one cycle per write and never in IDLE, PTR, DATA or DONE.
- Latency from the start edge to done (zero-wait memory): mode 0: 2; mode 1/2/4: 3; mode 3/5/6: 4; mode 7: 5 cycles. Each memory wait cycle adds 1.

Decomposition:
- Package pdp11_pkg holds: addressing-mode constants (MODE_REG..MODE_IDX_DEF), REG_SP = 6, REG_PC = 7, and the state enum.
- Single module; no sub-module. Step/next-address arithmetic stays inline.

Test Plan:
- Mode 0, R3 = 0o1234, word: done 2 cycles after start; operand = 0o1234; ea_valid = 0; no mem_req.
- Mode 2, R1 = 0o1001, byte, mem[0o1000] = 0o123456: R1 becomes 0o1002; mem_addr = 0o1000; operand = 0o000247 (hi byte); ea = 0o1001.
- Mode 4 byte on R6 = 0o2000: SP becomes 0o1776 (step 2); ea = 0o1776.
- Mode 6 on R7: PC = 0o100, mem[0o100] = 0o20, fetch = 0. Result: PC = 0o102; ea = 0o122; done with no data read.
- Mode 3 word, R0 = 0o400, mem[0o400] = 0o1001: R0 = 0o402; odd_err pulse; no done; busy drops.
- Reset asserted during a DATA wait with mem_ack low. Required: next cycle state IDLE, mem_req = 0, busy = 0. A subsequent start behaves normally.

Source files
------------

// File: rtl/pdp11_pkg.sv
// Shared PDP-11 definitions: addressing modes, special registers and the
// operand-fetch sequencer state encoding.
package pdp11_pkg;

    // Addressing modes, spec[5:3]
    localparam logic [2:0] MODE_REG         = 3'd0;
    localparam logic [2:0] MODE_REG_DEF     = 3'd1;
    localparam logic [2:0] MODE_AUTOINC     = 3'd2;
    localparam logic [2:0] MODE_AUTOINC_DEF = 3'd3;
    localparam logic [2:0] MODE_AUTODEC     = 3'd4;
    localparam logic [2:0] MODE_AUTODEC_DEF = 3'd5;
    localparam logic [2:0] MODE_IDX         = 3'd6;
    localparam logic [2:0] MODE_IDX_DEF     = 3'd7;

    // Registers that never use a byte-sized step
    localparam logic [2:0] REG_SP = 3'd6;
    localparam logic [2:0] REG_PC = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IDX,
        ST_REG,
        ST_PTR,
        ST_DATA,
        ST_DONE
    } of_state_t;

endpackage

// File: rtl/operand_fetch.sv
// PDP-11 addressing-mode sequencer: walks an operand specifier through index
// fetch, register update, pointer fetch and data fetch, driving the register
// file and a request/acknowledge memory port, and hands EA and operand to
// the execute stage.
module operand_fetch
    import pdp11_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [5:0]    spec,
    input  logic          byte_op,
    input  logic          fetch,
    output logic [2:0]    rf_sela,
    output logic [2:0]    rf_selb,
    output logic          rf_we,
    output logic [AW-1:0] rf_w,
    input  logic [AW-1:0] rf_a,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [AW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ea,
    output logic          ea_valid,
    output logic [AW-1:0] operand,
    output logic          odd_err
);

    of_state_t     state_q, state_d;
    logic [2:0]    mode_q, mode_d;
    logic [2:0]    rn_q, rn_d;
    logic          byte_q, byte_d;
    logic          fetch_q, fetch_d;
    logic [AW-1:0] x_q, x_d;
    logic [AW-1:0] tmp_q, tmp_d;
    logic [AW-1:0] ea_q, ea_d;
    logic          ea_valid_q, ea_valid_d;
    logic [AW-1:0] operand_q, operand_d;
    logic [AW-1:0] step;

    // Byte autoinc/autodec moves by 1, except on SP/PC which stay word aligned
    always_comb begin
        step = AW'(2);
        if (byte_q && (rn_q < REG_SP) &&
            (mode_q == MODE_AUTOINC || mode_q == MODE_AUTODEC))
            step = AW'(1);
    end

    // Sequencer: next state, register-file and memory-port controls
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d    = state_q;
        mode_d     = mode_q;
        rn_d       = rn_q;
        byte_d     = byte_q;
        fetch_d    = fetch_q;
        x_d        = x_q;
        tmp_d      = tmp_q;
        ea_d       = ea_q;
        ea_valid_d = ea_valid_q;
        operand_d  = operand_q;
        rf_sela    = rn_q;
        rf_selb    = rn_q;
        rf_we      = 1'b0;
        rf_w       = '0;
        mem_req    = 1'b0;
        mem_addr   = tmp_q;
        odd_err    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = spec[5:3];
                    rn_d    = spec[2:0];
                    byte_d  = byte_op;
                    fetch_d = fetch;
                    state_d = (spec[5:3] == MODE_IDX || spec[5:3] == MODE_IDX_DEF)
                              ? ST_IDX : ST_REG;
                end
            end

            ST_IDX: begin
                rf_sela  = REG_PC;
                mem_req  = 1'b1;
                mem_addr = rf_a;
                if (mem_ack) begin
                    x_d     = mem_rdata;
                    rf_selb = REG_PC;
                    rf_we   = 1'b1;
                    rf_w    = rf_a + AW'(2);
                    state_d = ST_REG;
                end
            end

            ST_REG: begin
                unique case (mode_q)
                    MODE_REG, MODE_REG_DEF: tmp_d = rf_a;
                    MODE_AUTOINC, MODE_AUTOINC_DEF: begin
                        tmp_d = rf_a;
                        rf_we = 1'b1;
                        rf_w  = rf_a + step;
                    end
                    MODE_AUTODEC, MODE_AUTODEC_DEF: begin
                        tmp_d = rf_a - step;
                        rf_we = 1'b1;
                        rf_w  = rf_a - step;
                    end
                    default: tmp_d = rf_a + x_q;
                endcase

                if (mode_q == MODE_AUTOINC_DEF || mode_q == MODE_AUTODEC_DEF ||
                    mode_q == MODE_IDX_DEF) begin
                    state_d = ST_PTR;
                end else if (mode_q == MODE_REG) begin
                    operand_d = byte_q ? {{(AW-8){1'b0}}, rf_a[7:0]} : rf_a;
                    state_d   = ST_DONE;
                end else begin
                    state_d = fetch_q ? ST_DATA : ST_DONE;
                end
            end

            ST_PTR: begin
                if (tmp_q[0]) begin
                    odd_err = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = tmp_q;
                    if (mem_ack) begin
                        tmp_d   = mem_rdata;
                        state_d = fetch_q ? ST_DATA : ST_DONE;
                    end
                end
            end

            ST_DATA: begin
                if (!byte_q && tmp_q[0]) begin
                    odd_err = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = {tmp_q[AW-1:1], 1'b0};
                    if (mem_ack) begin
                        if (byte_q)
                            operand_d = {{(AW-8){1'b0}},
                                         tmp_q[0] ? mem_rdata[15:8] : mem_rdata[7:0]};
                        else
                            operand_d = mem_rdata;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        // EA is captured on entry to DONE so it is valid alongside done
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            ea_d       = tmp_d;
            ea_valid_d = (mode_q != MODE_REG);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q    <= ST_IDLE;
            ea_q       <= '0;
            ea_valid_q <= 1'b0;
            operand_q  <= '0;
        end else begin
            state_q    <= state_d;
            ea_q       <= ea_d;
            ea_valid_q <= ea_valid_d;
            operand_q  <= operand_d;
        end
        // NOTE: these are only read after being loaded in the same sequence, so they carry no reset.
        mode_q  <= mode_d;
        rn_q    <= rn_d;
        byte_q  <= byte_d;
        fetch_q <= fetch_d;
        x_q     <= x_d;
        tmp_q   <= tmp_d;
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign ea       = ea_q;
    assign ea_valid = ea_valid_q;
    assign operand  = operand_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: register file and memory are
// modelled here; every transaction is predicted by a mode-level reference.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset, start, byte_op, fetch, mem_ack;
    logic [5:0]  spec;
    logic [2:0]  rf_sela, rf_selb;
    logic        rf_we, mem_req, busy, done, ea_valid, odd_err;
    logic [15:0] rf_w, rf_a, mem_addr, mem_rdata, ea, operand;

    operand_fetch #(.AW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .spec(spec), .byte_op(byte_op),
        .fetch(fetch), .rf_sela(rf_sela), .rf_selb(rf_selb), .rf_we(rf_we),
        .rf_w(rf_w), .rf_a(rf_a), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .ea(ea), .ea_valid(ea_valid), .operand(operand), .odd_err(odd_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- register file ----------------
    logic [15:0] rf      [8];
    logic [15:0] rf_init [8];
    logic        rf_load = 1'b0;
    int          we_bad  = 0;

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
        end else if (rf_we) begin
            rf[rf_selb] <= rf_w;
        end
    end
    assign rf_a = rf[rf_sela];

    always @(negedge clk) if (rf_we && (!busy || done)) we_bad++;

    // ---------------- memory ----------------
    logic [15:0] mem [32768];
    int          wait_left  = 0;
    int          waits      = 0;
    int          acks       = 0;
    int          req_cycles = 0;
    logic [15:0] last_addr  = '0;
    logic        hold_ack   = 1'b0;
    logic        spurious   = 1'b0;
    int          max_wait   = 0;

    always @(negedge clk) begin
        if (mem_req) begin
            req_cycles++;
            if (wait_left == 0 && !hold_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[15:1]];
                last_addr = mem_addr;
                acks++;
                wait_left = $urandom_range(max_wait, 0);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                waits++;
                if (wait_left > 0) wait_left--;
            end
        end else begin
            mem_ack   = spurious ? 1'($urandom_range(1, 0)) : 1'b0;
            mem_rdata = 16'($urandom);
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] e_rf [8];
    logic [15:0] e_ea, e_operand;
    logic        e_ea_valid, e_err, e_chk_op;
    int          e_acks, e_lat;

    task automatic model(input logic [2:0] m, input logic [2:0] r, input logic b, input logic f);
        logic [15:0] x, ptr, a, w;
        logic [15:0] st;
        x = '0; ptr = '0; a = '0;
        for (int i = 0; i < 8; i++) e_rf[i] = rf_init[i];
        e_err = 1'b0; e_acks = 0; e_ea_valid = (m != 3'd0);
        st = (b && r < 3'd6 && (m == 3'd2 || m == 3'd4)) ? 16'd1 : 16'd2;
        if (m >= 3'd6) begin
            x = mem[e_rf[7][15:1]];
            e_rf[7] = e_rf[7] + 16'd2;
            e_acks++;
        end
        case (m)
            3'd0, 3'd1: a = e_rf[r];
            3'd2: begin a = e_rf[r]; e_rf[r] = e_rf[r] + st; end
            3'd3: begin ptr = e_rf[r]; e_rf[r] = e_rf[r] + 16'd2; end
            3'd4: begin e_rf[r] = e_rf[r] - st; a = e_rf[r]; end
            3'd5: begin e_rf[r] = e_rf[r] - 16'd2; ptr = e_rf[r]; end
            3'd6: a = e_rf[r] + x;
            default: ptr = e_rf[r] + x;
        endcase
        if (m == 3'd3 || m == 3'd5 || m == 3'd7) begin
            if (ptr[0]) e_err = 1'b1;
            else begin a = mem[ptr[15:1]]; e_acks++; end
        end
        e_ea = a;
        if (m == 3'd0) begin
            e_operand = b ? {8'h0, a[7:0]} : a;
        end else if (!e_err && f) begin
            if (!b && a[0]) e_err = 1'b1;
            else begin
                w = mem[a[15:1]];
                e_acks++;
                e_operand = b ? {8'h0, (a[0] ? w[15:8] : w[7:0])} : w;
            end
        end
        e_chk_op = f || (m == 3'd0);
        case (m)
            3'd0: e_lat = 2;
            3'd1, 3'd2, 3'd4: e_lat = 3;
            3'd3, 3'd5, 3'd6: e_lat = 4;
            default: e_lat = 5;
        endcase
        if (m != 3'd0 && !f) e_lat = e_lat - 1;
    endtask

    task automatic load_regs();
        @(negedge clk); rf_load = 1'b1;
        @(negedge clk); rf_load = 1'b0;
    endtask

    // One complete transaction compared against the model
    task automatic run_op(input logic [2:0] m, input logic [2:0] r, input logic b, input logic f);
        int w0, a0, q0, lat;
        logic got_done, got_err;
        model(m, r, b, f);
        w0 = waits; a0 = acks; q0 = req_cycles;
        @(negedge clk);
        spec = {m, r}; byte_op = b; fetch = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1; got_done = 1'b0; got_err = 1'b0;
        while (lat < 400) begin
            if (done) begin got_done = 1'b1; break; end
            if (odd_err) begin got_err = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        check("end_kind", {30'd0, got_done, got_err}, e_err ? 32'd1 : 32'd2);
        if (got_done) begin
            check("latency", lat, e_lat + (waits - w0));
            check("ea", ea, e_ea);
            check("ea_valid", ea_valid, e_ea_valid);
            if (e_chk_op) check("operand", operand, e_operand);
        end
        check("mem_acks", acks - a0, e_acks);
        check("req_cycles", req_cycles - q0, e_acks + (waits - w0));
        @(negedge clk);
        check("busy_after", busy, 1'b0);
        check("pulse_len", {done, odd_err}, 2'b00);
        for (int i = 0; i < 8; i++) check($sformatf("R%0d", i), rf[i], e_rf[i]);
    endtask

    initial begin
        int k;
        reset = 1'b1; start = 1'b0; spec = '0; byte_op = 1'b0; fetch = 1'b0;
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(3, 0) != 0) mem[i][0] = 1'b0;
        end
        for (int i = 0; i < 8; i++) rf_init[i] = 16'(i * 16'o100);
        rf_load = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_odd_err", odd_err, 1'b0);
        check("rst_ea_valid", ea_valid, 1'b0);
        check("rst_ea", ea, 16'h0);
        check("rst_operand", operand, 16'h0);
        reset = 1'b0; rf_load = 1'b0;

        // Mode 0, R3, word
        rf_init[3] = 16'o1234; load_regs();
        run_op(3'd0, 3'd3, 1'b0, 1'b1);
        check("m0_operand", operand, 16'o1234);

        // Mode 2 byte on odd R1: hi byte, step 1
        rf_init[1] = 16'o1001; mem[16'o1000 >> 1] = 16'o123456; load_regs();
        run_op(3'd2, 3'd1, 1'b1, 1'b1);
        check("m2_addr", last_addr, 16'o1000);
        check("m2_operand", operand, 16'o000247);
        check("m2_r1", rf[1], 16'o1002);
        check("m2_ea", ea, 16'o1001);

        // Mode 4 byte on SP: step stays 2
        rf_init[6] = 16'o2000; load_regs();
        run_op(3'd4, 3'd6, 1'b1, 1'b1);
        check("m4_sp", rf[6], 16'o1776);
        check("m4_ea", ea, 16'o1776);

        // Mode 6 on PC, EA only
        rf_init[7] = 16'o100; mem[16'o100 >> 1] = 16'o20; load_regs();
        run_op(3'd6, 3'd7, 1'b0, 1'b0);
        check("m6_pc", rf[7], 16'o102);
        check("m6_ea", ea, 16'o122);

        // Mode 3 word, pointer is odd
        rf_init[0] = 16'o400; mem[16'o400 >> 1] = 16'o1001; load_regs();
        run_op(3'd3, 3'd0, 1'b0, 1'b1);
        check("m3_r0", rf[0], 16'o402);

        // Reset while stalled in a data wait
        rf_init[2] = 16'o3000; load_regs();
        hold_ack = 1'b1;
        @(negedge clk); spec = {3'd1, 3'd2}; byte_op = 1'b0; fetch = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!mem_req && k < 10) begin @(negedge clk); k++; end
        check("wait_req", mem_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("rstw_mem_req", mem_req, 1'b0);
        check("rstw_busy", busy, 1'b0);
        check("rstw_done", done, 1'b0);
        reset = 1'b0; hold_ack = 1'b0;
        run_op(3'd1, 3'd2, 1'b0, 1'b1);

        // Randomised transactions with wait states and stray acks
        max_wait = 3; spurious = 1'b1;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 8; i++) begin
                rf_init[i] = 16'($urandom);
                if ($urandom_range(7, 0) != 0) rf_init[i][0] = 1'b0;
            end
            rf_init[7][0] = 1'b0;
            load_regs();
            run_op(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                   1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        check("rf_we_outside_seq", we_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
